// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the CPU core control blocks.
//   seq_state_t      - sequencer FSM encoding
//   STATE_FETCH/EXEC - encoding of the 1-bit 'state' output seen by PC/regfile
//   ADDR_SEL_PC/ALU  - memory bus address mux select
package cpu_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } seq_state_t;

  localparam logic STATE_FETCH  = 1'b0;
  localparam logic STATE_EXEC   = 1'b1;

  localparam logic ADDR_SEL_PC  = 1'b0;
  localparam logic ADDR_SEL_ALU = 1'b1;

endpackage

// File: rtl/cpu_sequencer_bus_watchdog.sv
// bus_watchdog: counts consecutive stalled bus cycles of one access and
// flags a timeout once the count reaches MAX_WAIT.
//   clk, rst_n      - clock, async active-low reset
//   i_strobe        - a bus strobe (read or write) is asserted this cycle
//   i_waitrequest   - bus not ready
//   i_clear         - sequencer changes state at the next edge
//   o_timeout       - this stalled cycle is the MAX_WAIT-th one in a row
module bus_watchdog #(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_strobe,
  input  logic i_waitrequest,
  input  logic i_clear,
  output logic o_timeout
);

  localparam logic [WAIT_W-1:0] CNT_SAT = '1;

  logic [WAIT_W-1:0] r_cnt;
  logic              w_waiting;

  assign w_waiting = i_strobe & i_waitrequest;

  // Saturating counter: with the watchdog disabled it may sit at all-ones
  // for arbitrarily long waits without wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!w_waiting || i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_SAT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Timeout fires in the cycle whose edge would bring the count to MAX_WAIT,
  // so bus_error is visible right after the MAX_WAIT-th wait cycle.
  generate
    if (MAX_WAIT == 0) begin : g_disabled
      assign o_timeout = 1'b0;
    end else begin : g_enabled
      localparam logic [WAIT_W-1:0] LIMIT_M1 = WAIT_W'(MAX_WAIT - 1);
      assign o_timeout = w_waiting & (r_cnt == LIMIT_M1);
    end
  endgenerate

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multicycle FETCH/EXEC control sequencer for the CPU core.
// Arbitrates the single memory bus between instruction fetch and data
// load/store, detects halt (fetch of address 0) and bus-wait timeouts.
//   clk, reset      - clock, async active-low reset
//   waitrequest     - bus not ready, hold current access
//   finish          - PC is the exit address (evaluated in FETCH only)
//   data_read/write - decoded load/store (EXEC)
//   alu_busy        - multi-cycle ALU still computing (EXEC)
//   state           - 0 FETCH, 1 EXEC (HALT also reads 1)
//   stall, mem_read, mem_write, addr_sel, ir_load, commit - control outputs
//   active          - running; low after halt or bus error
//   bus_error       - sticky watchdog expiry flag
//
// state   | meaning
// S_FETCH | read instruction at PC into IR
// S_EXEC  | execute, optional load/store via ALU address, commit
// S_HALT  | stopped by finish or bus error; only reset leaves
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic waitrequest,
  input  logic finish,
  input  logic data_read,
  input  logic data_write,
  input  logic alu_busy,
  output logic state,
  output logic stall,
  output logic mem_read,
  output logic mem_write,
  output logic addr_sel,
  output logic ir_load,
  output logic commit,
  output logic active,
  output logic bus_error
);

  seq_state_t r_state;
  seq_state_t w_next;
  logic       r_bus_error;
  logic       w_timeout;
  logic       w_mem_access;
  logic       w_exec_stall;
  logic       w_strobe;
  logic       w_state_chg;

  assign w_mem_access = data_read | data_write;
  assign w_exec_stall = (w_mem_access & waitrequest) | alu_busy;

  always_comb begin
    w_next    = r_state;
    state     = STATE_FETCH;
    stall     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr_sel  = ADDR_SEL_PC;
    ir_load   = 1'b0;
    commit    = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (finish) begin
          stall  = 1'b1;
          w_next = S_HALT;
        end else begin
          mem_read = 1'b1;
          if (waitrequest) begin
            stall = 1'b1;
          end else begin
            ir_load = 1'b1;
            w_next  = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        state     = STATE_EXEC;
        addr_sel  = w_mem_access ? ADDR_SEL_ALU : ADDR_SEL_PC;
        mem_read  = data_read;
        mem_write = data_write & ~data_read;
        stall     = w_exec_stall;
        commit    = ~w_exec_stall;
        if (!w_exec_stall) w_next = S_FETCH;
      end
      S_HALT: begin
        state = STATE_EXEC;
        stall = 1'b1;
      end
      default: begin
        w_next = S_HALT;
      end
    endcase

    if (w_timeout) w_next = S_HALT;

    // While reset is held every control output is forced low so that an
    // access in flight is abandoned immediately and nothing commits.
    if (!reset) begin
      stall     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      addr_sel  = ADDR_SEL_PC;
      ir_load   = 1'b0;
      commit    = 1'b0;
    end
  end

  assign w_strobe    = mem_read | mem_write;
  assign w_state_chg = (w_next != r_state);

  bus_watchdog #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_bus_watchdog (
    .clk           (clk),
    .rst_n         (reset),
    .i_strobe      (w_strobe),
    .i_waitrequest (waitrequest),
    .i_clear       (w_state_chg),
    .o_timeout     (w_timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_FETCH;
      r_bus_error <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_timeout) r_bus_error <= 1'b1;
    end
  end

  assign active    = (r_state != S_HALT);
  assign bus_error = r_bus_error;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic waitrequest = 1'b0, finish = 1'b0, data_read = 1'b0;
  logic data_write = 1'b0, alu_busy = 1'b0;
  logic state, stall, mem_read, mem_write, addr_sel, ir_load, commit, active, bus_error;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: phase 0 fetch, 1 exec, 2 halted.
  int m_ph    = 0;
  int m_waits = 0;
  bit m_err   = 1'b0;

  always #5 clk = ~clk;

  cpu_sequencer #(.MAX_WAIT(MAXW), .WAIT_W(5)) dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .finish(finish),
    .data_read(data_read), .data_write(data_write), .alu_busy(alu_busy),
    .state(state), .stall(stall), .mem_read(mem_read), .mem_write(mem_write),
    .addr_sel(addr_sel), .ir_load(ir_load), .commit(commit), .active(active),
    .bus_error(bus_error)
  );

  wire [8:0] obs = {state, stall, mem_read, mem_write, addr_sel, ir_load, commit, active, bus_error};

  // {state,stall,mem_read,mem_write,addr_sel,ir_load,commit,active,bus_error}
  function automatic logic [8:0] model_out();
    logic st, sl, mr, mw, as, il, cm;
    st = 0; sl = 0; mr = 0; mw = 0; as = 0; il = 0; cm = 0;
    if (!reset) return 9'b000000010;
    if (m_ph == 0) begin
      if (finish) sl = 1;
      else begin mr = 1; sl = waitrequest; il = !waitrequest; end
    end else if (m_ph == 1) begin
      st = 1;
      as = data_read || data_write;
      mr = data_read;
      mw = data_write && !data_read;
      sl = (as && waitrequest) || alu_busy;
      cm = !sl;
    end else begin
      st = 1; sl = 1;
    end
    return {st, sl, mr, mw, as, il, cm, (m_ph != 2), m_err};
  endfunction

  task automatic model_advance();
    logic [8:0] e;
    int nph;
    if (!reset) begin m_ph = 0; m_waits = 0; m_err = 0; return; end
    e = model_out();
    nph = m_ph;
    if ((e[6] || e[5]) && waitrequest) m_waits++; else m_waits = 0;
    if (m_waits >= MAXW) begin
      m_err = 1; nph = 2;
    end else if (m_ph == 0) begin
      if (finish) nph = 2; else if (!waitrequest) nph = 1;
    end else if (m_ph == 1) begin
      if (!e[7]) nph = 0;
    end
    if (nph != m_ph) m_waits = 0;
    m_ph = nph;
  endtask

  task automatic drive(input logic wr, input logic fin, input logic dr, input logic dw, input logic ab);
    waitrequest = wr; finish = fin; data_read = dr; data_write = dw; alu_busy = ab;
    @(negedge clk);
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 0;
    waitrequest = 0; finish = 0; data_read = 0; data_write = 0; alu_busy = 0;
    m_ph = 0; m_waits = 0; m_err = 0;
    @(posedge clk); #1;
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0; waitrequest = 0; finish = 0; data_read = 0; data_write = 0; alu_busy = 0;
    m_ph = 0; m_waits = 0; m_err = 0;
    @(negedge clk);
    n_total++;
    if (obs !== 9'b000000010) $display("FAIL reset_outputs got %b exp %b", obs, 9'b000000010);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1;
    drive(0, 0, 0, 0, 0);
    n_total++;
    if (mem_read !== 1'b1 || state !== 1'b0) $display("FAIL reset_release mem_read=%b state=%b exp 1 0", mem_read, state);
    else n_pass++;
    tick();
  endtask

  task automatic test_alu_toggle();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0);
      n_total++;
      if (state !== 1'(i % 2) || ir_load !== 1'(i % 2 == 0) || commit !== 1'(i % 2) || stall !== 1'b0)
        $display("FAIL alu_toggle cyc %0d state=%b ir_load=%b commit=%b stall=%b", i, state, ir_load, commit, stall);
      else n_pass++;
      n_total++;
      if (obs !== model_out()) $display("FAIL alu_toggle_model cyc %0d got %b exp %b", i, obs, model_out());
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_fetch_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0);
      n_total++;
      if (mem_read !== 1'b1 || stall !== 1'b1 || ir_load !== 1'b0)
        $display("FAIL fetch_wait cyc %0d mem_read=%b stall=%b ir_load=%b exp 1 1 0", i, mem_read, stall, ir_load);
      else n_pass++;
      tick();
    end
    drive(0, 0, 0, 0, 0);
    n_total++;
    if (ir_load !== 1'b1 || stall !== 1'b0) $display("FAIL fetch_done ir_load=%b stall=%b exp 1 0", ir_load, stall);
    else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0);
    n_total++;
    if (state !== 1'b1) $display("FAIL fetch_to_exec state=%b exp 1", state);
    else n_pass++;
    tick();
  endtask

  task automatic test_load_wait();
    do_reset();
    drive(0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(i < 2, 0, 1, 0, 0);
      n_total++;
      if (addr_sel !== 1'b1 || mem_read !== 1'b1 || commit !== 1'(i == 2) || state !== 1'b1)
        $display("FAIL load_wait cyc %0d addr_sel=%b mem_read=%b commit=%b state=%b", i, addr_sel, mem_read, commit, state);
      else n_pass++;
      tick();
    end
    drive(0, 0, 0, 0, 0);
    n_total++;
    if (state !== 1'b0) $display("FAIL load_to_fetch state=%b exp 0", state);
    else n_pass++;
    tick();
  endtask

  task automatic test_store();
    do_reset();
    drive(0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    n_total++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || commit !== 1'b1 || addr_sel !== 1'b1)
      $display("FAIL store mem_write=%b mem_read=%b commit=%b addr_sel=%b exp 1 0 1 1", mem_write, mem_read, commit, addr_sel);
    else n_pass++;
    tick();
    drive(0, 0, 0, 1, 0);
    n_total++;
    if (state !== 1'b0 || mem_write !== 1'b0 || commit !== 1'b0)
      $display("FAIL store_once state=%b mem_write=%b commit=%b exp 0 0 0", state, mem_write, commit);
    else n_pass++;
    tick();
    // read wins over write in EXEC
    drive(0, 0, 1, 1, 0);
    n_total++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0)
      $display("FAIL read_wins mem_read=%b mem_write=%b exp 1 0", mem_read, mem_write);
    else n_pass++;
    tick();
  endtask

  task automatic test_alu_busy();
    do_reset();
    drive(0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 0, i < 5);
      n_total++;
      if (stall !== 1'(i < 5) || mem_read !== 1'b0 || mem_write !== 1'b0 || commit !== 1'(i == 5))
        $display("FAIL alu_busy cyc %0d stall=%b mem_read=%b mem_write=%b commit=%b", i, stall, mem_read, mem_write, commit);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_halt();
    do_reset();
    drive(0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    n_total++;
    if (state !== 1'b0 || active !== 1'b1)
      $display("FAIL finish_in_exec state=%b active=%b exp 0 1", state, active);
    else n_pass++;
    drive(0, 1, 0, 0, 0);
    n_total++;
    if (mem_read !== 1'b0) $display("FAIL finish_no_read mem_read=%b exp 0", mem_read);
    else n_pass++;
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      n_total++;
      if (obs !== 9'b110000000) $display("FAIL halt_hold cyc %0d got %b exp %b", i, obs, 9'b110000000);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 0; i < MAXW; i++) begin
      drive(1, 0, 0, 0, 0);
      n_total++;
      if (mem_read !== 1'b1 || bus_error !== 1'b0 || active !== 1'b1)
        $display("FAIL wd_wait cyc %0d mem_read=%b bus_error=%b active=%b", i, mem_read, bus_error, active);
      else n_pass++;
      tick();
    end
    drive(1, 0, 0, 0, 0);
    n_total++;
    if (bus_error !== 1'b1 || active !== 1'b0 || mem_read !== 1'b0)
      $display("FAIL wd_expire bus_error=%b active=%b mem_read=%b exp 1 0 0", bus_error, active, mem_read);
    else n_pass++;
    #2 reset = 0;
    m_ph = 0; m_waits = 0; m_err = 0;
    #1;
    n_total++;
    if (bus_error !== 1'b0 || active !== 1'b1)
      $display("FAIL wd_async_clear bus_error=%b active=%b exp 0 1", bus_error, active);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1;
    drive(0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 1, 0, 0);
    n_total++;
    if (mem_read !== 1'b1 || state !== 1'b1) $display("FAIL wd_load mem_read=%b state=%b exp 1 1", mem_read, state);
    else n_pass++;
    #2 reset = 0;
    m_ph = 0; m_waits = 0; m_err = 0;
    #1;
    n_total++;
    if (mem_read !== 1'b0 || commit !== 1'b0 || state !== 1'b0 || stall !== 1'b0)
      $display("FAIL wd_reset_mid_access mem_read=%b commit=%b state=%b stall=%b", mem_read, commit, state, stall);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 3) == 0, ($urandom % 24) == 0, 1'($urandom), 1'($urandom), ($urandom % 4) == 0);
      n_total++;
      if (obs !== model_out()) $display("FAIL random cyc %0d got %b exp %b", i, obs, model_out());
      else n_pass++;
      tick();
      if (m_ph == 2 && ($urandom % 4) == 0) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_alu_toggle();
    test_fetch_wait();
    test_load_wait();
    test_store();
    test_alu_busy();
    test_halt();
    test_watchdog();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multicycle control sequencer for the CPU core. It generates the FETCH/EXEC `state` and the `stall` signal consumed by the program counter and register file. It arbitrates the single memory bus between instruction fetch and data load/store. It also detects halt (fetch of address 0) and bus-wait timeouts.

Parameters:
MAX_WAIT, 16, maximum consecutive waitrequest cycles per access before bus_error; 0 disables the watchdog
WAIT_W, 5, width of wait counter; must satisfy 2^WAIT_W > MAX_WAIT

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
waitrequest  input  1  memory bus not ready; current access must be held
finish  input  1  PC equals 0x00000000 (exit address)
data_read  input  1  decoded current instruction is a load (valid in EXEC)
data_write  input  1  decoded current instruction is a store (valid in EXEC)
alu_busy  input  1  multi-cycle mult/div unit still computing (valid in EXEC)
state  output  1  0 = FETCH, 1 = EXEC; drives PC update timing
stall  output  1  hold PC and suppress commit this cycle
mem_read  output  1  bus read strobe
mem_write  output  1  bus write strobe
addr_sel  output  1  0 = bus address from PC, 1 = from ALU result
ir_load  output  1  capture bus readdata into instruction register
commit  output  1  register-file write enable gate (one pulse per instruction)
active  output  1  CPU running; low after halt or error
bus_error  output  1  sticky; watchdog expired

Behaviour:
- FSM states: S_FETCH, S_EXEC, S_HALT.
- Reset (reset=0, async): FSM = S_FETCH, wait counter = 0, bus_error = 0, active = 1. All other outputs are combinational and read 0 except mem_read, which follows S_FETCH once reset is released.
- Outputs are combinational from FSM state and inputs (Moore/Mealy mix); no added latency.

S_FETCH (state=0, addr_sel=0):
- finish=1: no bus access (mem_read=0); next state S_HALT.
- Otherwise mem_read=1.
- waitrequest=1: stall=1, ir_load=0, remain in S_FETCH.
- waitrequest=0: ir_load=1, stall=0, next state S_EXEC.
- Instruction fetch therefore takes a minimum of 1 cycle, plus 1 per wait cycle.

S_EXEC (state=1):
- mem_access = data_read | data_write. addr_sel = mem_access. mem_read = data_read. mem_write = data_write & ~data_read.
- If both data_read and data_write are high, data_read wins.
- stall = (mem_access & waitrequest) | alu_busy.
- stall=1: commit=0, remain in S_EXEC. The bus strobe stays asserted with a stable addr_sel.
- stall=0: commit=1, next state S_FETCH. The PC updates on this edge.
- waitrequest is ignored when mem_access=0.

S_HALT:
- active=0, state=1, stall=1. All strobes, commit and ir_load are 0.
- Only reset exits this state.

Watchdog:
- The counter increments each cycle a strobe is high and waitrequest=1. It clears on any cycle with waitrequest=0 or no strobe, and on every state change.
- When MAX_WAIT≠0 and the counter reaches MAX_WAIT with waitrequest still 1: bus_error←1 and next state S_HALT. The strobe drops the following cycle.
- The counter saturates and never wraps.
- MAX_WAIT=0: the counter is never compared; waits are unbounded.

Boundary conditions:
- finish rising in S_EXEC is ignored; it is evaluated only in S_FETCH.
- alu_busy together with a store is invalid; the FSM still stalls and the store strobe stays held.
- Reset asserted mid-access drops all strobes immediately (async). No partial commit occurs.

Decomposition:
- Shared package cpu_pkg holds:
  - the seq_state_t enum (S_FETCH=2'd0, S_EXEC=2'd1, S_HALT=2'd2)
  - constants STATE_FETCH=1'b0 and STATE_EXEC=1'b1, shared with the PC and control blocks
  - the ADDR_SEL_PC/ADDR_SEL_ALU encodings
- One natural sub-module, bus_watchdog: wait counter plus compare, emitting timeout. Everything else stays in a single always_ff/always_comb pair.

Test Plan:
- Reset release, waitrequest=0, plain ALU op → state toggles 0,1,0,1. ir_load pulses in cycles 0 and 2; commit pulses in cycles 1 and 3; stall stays 0.
- FETCH with waitrequest high for 3 cycles → mem_read=1 and stall=1 for 3 cycles. ir_load fires on cycle 4, then state=1.
- EXEC load with 2 wait cycles → addr_sel=1, mem_read=1 for 3 cycles. commit pulses only on the 3rd cycle, then FETCH.
- EXEC store with alu_busy=0, waitrequest=0 → mem_write=1, mem_read=0, commit=1 for exactly 1 cycle.
- EXEC with alu_busy high for 5 cycles → stall=1 for 5 cycles, no strobes, commit on cycle 6.
- finish=1 in FETCH → no mem_read, then S_HALT with active=0 held for 20 cycles.
- MAX_WAIT=4, waitrequest stuck at 1 → bus_error=1 after the 4th wait cycle, then active=0. Asserting reset=0 mid-wait clears bus_error and strobes asynchronously.
